seq_pattern_tx: RTL

//  Serial pattern transmitter; counterpart of the 111010 sequence detector.

---
 rtl/seq_pattern_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, counterpart of the 111010 sequence detector.
// Emits PATTERN MSB-first on x_out, one bit per clk, repeated a latched number of times with a
// latched run of idle zeros between repeats. All outputs are registered.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   burst request, sampled only in IDLE (ignored when reps == 0)
//   abort     in   synchronous cancel of the current burst (no done pulse)
//   reps      in   [RW] number of pattern repeats, latched on an accepted start
//   gap       in   [GW] zero bits between repeats, latched on an accepted start
//   x_out     out  serial data
//   frame     out  high while x_out carries a pattern bit
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse after the last bit of the last repeat
//   rep_left  out  [RW] repeats still to start, counting the one in flight
module seq_pattern_tx #(
  parameter int unsigned     PLEN    = 6,
  parameter logic [PLEN-1:0] PATTERN = 6'b111010,
  parameter int unsigned     RW      = 8,
  parameter int unsigned     GW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [RW-1:0] reps,
  input  logic [GW-1:0] gap,
  output logic          x_out,
  output logic          frame,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rep_left
);

  localparam int unsigned BW = (PLEN > 2) ? $clog2(PLEN) : 1;
  localparam logic [BW-1:0] LastBit = BW'(PLEN - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;     // index of the pattern bit currently on x_out
  logic [GW-1:0] gcnt_q, gcnt_d;     // gap cycles remaining, including the current one
  logic [GW-1:0] gap_l_q, gap_l_d;
  logic [RW-1:0] rep_left_q, rep_left_d;
  logic          x_out_q, x_out_d;
  logic          frame_q, frame_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    gcnt_d     = gcnt_q;
    gap_l_d    = gap_l_q;
    rep_left_d = rep_left_q;
    x_out_d    = 1'b0;
    frame_d    = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start && (reps != '0)) begin
          state_d    = StSend;
          rep_left_d = reps;
          gap_l_d    = gap;
          bcnt_d     = LastBit;
          x_out_d    = PATTERN[PLEN-1];
          frame_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StSend: begin
        if (bcnt_q != '0) begin
          bcnt_d  = bcnt_q - BW'(1);
          x_out_d = PATTERN[bcnt_d];
          frame_d = 1'b1;
        end else begin
          // Last bit of this repeat is on x_out now.
          rep_left_d = rep_left_q - RW'(1);
          if (rep_left_q == RW'(1)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (gap_l_q == '0) begin
            bcnt_d  = LastBit;
            x_out_d = PATTERN[PLEN-1];
            frame_d = 1'b1;
          end else begin
            state_d = StGap;
            gcnt_d  = gap_l_q;
          end
        end
      end
      StGap: begin
        if (gcnt_q == GW'(1)) begin
          state_d = StSend;
          bcnt_d  = LastBit;
          x_out_d = PATTERN[PLEN-1];
          frame_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      StDone: begin
        state_d    = StIdle;
        busy_d     = 1'b0;
        rep_left_d = '0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over every transition out of a busy state.
    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      rep_left_d = '0;
      x_out_d    = 1'b0;
      frame_d    = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bcnt_q     <= '0;
      gcnt_q     <= '0;
      gap_l_q    <= '0;
      rep_left_q <= '0;
      x_out_q    <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      gcnt_q     <= gcnt_d;
      gap_l_q    <= gap_l_d;
      rep_left_q <= rep_left_d;
      x_out_q    <= x_out_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign x_out    = x_out_q;
  assign frame    = frame_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rep_left = rep_left_q;

endmodule
